// File: rtl/jt10_seq_pkg.sv
// Shared definitions for the YM2610 accumulator slot sequencer.
//   SLOTS / CHANNELS : round geometry (4 operator stages x 6 FM channels)
//   stage_e          : operator stage; encoding equals slot/6 so the decode is a cast
//   cfg_t            : per-channel configuration word {alg, rl}
//   ch_code          : channel index 0..5 -> channel code {group, idx}
//   ch_valid         : channel codes 3 and 7 do not exist
//   ch_index         : channel code -> channel index 0..5
package jt10_seq_pkg;

  localparam int SLOTS    = 24;
  localparam int CHANNELS = 6;

  typedef enum logic [1:0] {
    ST_S1 = 2'd0,
    ST_S3 = 2'd1,
    ST_S2 = 2'd2,
    ST_S4 = 2'd3
  } stage_e;

  typedef struct packed {
    logic [2:0] alg;
    logic [1:0] rl;
  } cfg_t;

  localparam cfg_t CFG_RST = '{alg: 3'd0, rl: 2'b11};

  function automatic logic [2:0] ch_code(input logic [2:0] chidx);
    logic [2:0] hi;
    hi = chidx - 3'd3;
    ch_code = (chidx >= 3'd3) ? {1'b1, hi[1:0]} : {1'b0, chidx[1:0]};
  endfunction

  function automatic logic ch_valid(input logic [2:0] code);
    ch_valid = (code[1:0] != 2'b11);
  endfunction

  function automatic logic [2:0] ch_index(input logic [2:0] code);
    ch_index = code[2] ? (3'd3 + {1'b0, code[1:0]}) : {1'b0, code[1:0]};
  endfunction

endpackage

// File: rtl/jt10_adpcma_buf.sv
// ADPCM-A L/R double buffer.
// A sample accepted through the valid/ready handshake waits in the pending
// buffer; on the round boundary it moves to the output buffer so the
// accumulator sees one value for the whole round.
//   clk, rst_n        : clock, asynchronous active-low reset
//   round_xfer        : high on the edge that wraps slot 23 -> 0
//   in_valid/in_ready : handshake; in_ready = pending buffer empty
//   l_in, r_in        : offered sample
//   l_out, r_out      : round-stable sample
// Optional (JT10_ACC_SEQ_UNDERRUN_EN):
//   underrun_clr      : synchronous counter clear, wins over increment
//   underrun_cnt      : saturating count of rounds with no fresh sample
module jt10_adpcma_buf #(
  parameter int AW  = 16
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
  ,
  parameter int UCW = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 round_xfer,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [AW-1:0] l_in,
  input  logic signed [AW-1:0] r_in,
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
  input  logic                 underrun_clr,
  output logic [UCW-1:0]       underrun_cnt,
`endif
  output logic signed [AW-1:0] l_out,
  output logic signed [AW-1:0] r_out
);

  logic                 pend_full_q, pend_full_d;
  logic signed [AW-1:0] pl_q, pl_d, pr_q, pr_d;
  logic signed [AW-1:0] ol_q, ol_d, or_q, or_d;
  logic                 accept;

  assign in_ready = ~pend_full_q;
  assign accept   = in_valid & ~pend_full_q;

  // A transfer needs pend_full=1 while an accept needs pend_full=0, so the
  // two branches below never fire on the same edge.
  always_comb begin
    pend_full_d = pend_full_q;
    pl_d        = pl_q;
    pr_d        = pr_q;
    ol_d        = ol_q;
    or_d        = or_q;
    if (round_xfer && pend_full_q) begin
      ol_d        = pl_q;
      or_d        = pr_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pl_d        = l_in;
      pr_d        = r_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pl_q        <= '0;
      pr_q        <= '0;
      ol_q        <= '0;
      or_q        <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      ol_q        <= ol_d;
      or_q        <= or_d;
    end
  end

  assign l_out = ol_q;
  assign r_out = or_q;

`ifdef JT10_ACC_SEQ_UNDERRUN_EN
  logic [UCW-1:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr) begin
      ucnt_d = '0;
    end else if (round_xfer && !pend_full_q && (ucnt_q != '1)) begin
      ucnt_d = ucnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: rtl/jt10_acc_seq.sv
// Slot sequencer and configuration holder for the YM2610 accumulator.
// Walks the 24-slot round (stage order S1,S3,S2,S4; channels 0,1,2,4,5,6
// within each stage) and presents registered per-slot controls, the channel
// config {alg, rl} and a round-stable ADPCM-A sample.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clk_en              : slot advance enable
//   cfg_we/ch/alg/rl    : per-channel config write (any clk edge)
//   adpcma_valid/ready  : sample handshake; adpcma_l_in/r_in offered sample
//   adpcma_l/r          : sample for the accumulator, changes at round start
//   zero, cur_ch        : first-slot flag, current channel code
//   s1..s4_enters       : one-hot operator stage
//   alg, rl             : config of cur_ch
//   snd_valid           : one-clk pulse on the 23 -> 0 edge
// Build option JT10_ACC_SEQ_UNDERRUN_EN adds underrun_clr / underrun_cnt.
module jt10_acc_seq
  import jt10_seq_pkg::*;
#(
  parameter int AW  = 16,
  parameter int UCW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_ch,
  input  logic [2:0]           cfg_alg,
  input  logic [1:0]           cfg_rl,
  input  logic                 adpcma_valid,
  output logic                 adpcma_ready,
  input  logic signed [AW-1:0] adpcma_l_in,
  input  logic signed [AW-1:0] adpcma_r_in,
  output logic signed [AW-1:0] adpcma_l,
  output logic signed [AW-1:0] adpcma_r,
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
  input  logic                 underrun_clr,
  output logic [UCW-1:0]       underrun_cnt,
`endif
  output logic                 zero,
  output logic [2:0]           cur_ch,
  output logic                 s1_enters,
  output logic                 s2_enters,
  output logic                 s3_enters,
  output logic                 s4_enters,
  output logic [2:0]           alg,
  output logic [1:0]           rl,
  output logic                 snd_valid
);

  logic [4:0] slot_q, slot_d;
  logic       zero_q, zero_d;
  logic [2:0] cur_ch_q, cur_ch_d;
  logic [3:0] enters_q, enters_d;   // {s4, s3, s2, s1}
  logic [2:0] alg_q, alg_d;
  logic [1:0] rl_q, rl_d;
  logic       snd_valid_q, snd_valid_d;
  cfg_t       cfg_q [CHANNELS];
  cfg_t       cfg_d [CHANNELS];

  logic [4:0] nslot, nquot;
  logic [2:0] nchidx;
  stage_e     nstage;
  logic       last_slot;

  assign last_slot = (slot_q == 5'(SLOTS - 1));

  always_comb begin
    slot_d      = slot_q;
    zero_d      = zero_q;
    cur_ch_d    = cur_ch_q;
    enters_d    = enters_q;
    alg_d       = alg_q;
    rl_d        = rl_q;
    snd_valid_d = 1'b0;
    cfg_d       = cfg_q;

    nslot  = last_slot ? 5'd0 : slot_q + 5'd1;
    nquot  = nslot / 5'd6;
    nchidx = 3'(nslot % 5'd6);
    nstage = stage_e'(nquot[1:0]);

    if (cfg_we && ch_valid(cfg_ch)) begin
      cfg_d[ch_index(cfg_ch)] = '{alg: cfg_alg, rl: cfg_rl};
    end

    if (clk_en) begin
      slot_d      = nslot;
      zero_d      = (nslot == 5'd0);
      cur_ch_d    = ch_code(nchidx);
      // Reading cfg_d rather than cfg_q bypasses a write landing on this edge.
      alg_d       = cfg_d[nchidx].alg;
      rl_d        = cfg_d[nchidx].rl;
      snd_valid_d = last_slot;
      case (nstage)
        ST_S1:   enters_d = 4'b0001;
        ST_S3:   enters_d = 4'b0100;
        ST_S2:   enters_d = 4'b0010;
        ST_S4:   enters_d = 4'b1000;
        default: enters_d = 4'b0001;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      zero_q      <= 1'b1;
      cur_ch_q    <= '0;
      enters_q    <= 4'b0001;
      alg_q       <= CFG_RST.alg;
      rl_q        <= CFG_RST.rl;
      snd_valid_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cfg_q[i] <= CFG_RST;
    end else begin
      slot_q      <= slot_d;
      zero_q      <= zero_d;
      cur_ch_q    <= cur_ch_d;
      enters_q    <= enters_d;
      alg_q       <= alg_d;
      rl_q        <= rl_d;
      snd_valid_q <= snd_valid_d;
      cfg_q       <= cfg_d;
    end
  end

  assign zero      = zero_q;
  assign cur_ch    = cur_ch_q;
  assign s1_enters = enters_q[0];
  assign s2_enters = enters_q[1];
  assign s3_enters = enters_q[2];
  assign s4_enters = enters_q[3];
  assign alg       = alg_q;
  assign rl        = rl_q;
  assign snd_valid = snd_valid_q;

  jt10_adpcma_buf #(
    .AW  (AW)
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
    ,
    .UCW (UCW)
`endif
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .round_xfer   (clk_en & last_slot),
    .in_valid     (adpcma_valid),
    .in_ready     (adpcma_ready),
    .l_in         (adpcma_l_in),
    .r_in         (adpcma_r_in),
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt),
`endif
    .l_out        (adpcma_l),
    .r_out        (adpcma_r)
  );

endmodule

// File: tb/tb_jt10_acc_seq.sv
// Bench for jt10_acc_seq: directed stimulus pushes expected outputs into a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_jt10_acc_seq;

  localparam int AW  = 16;
  localparam int UCW = 8;

  logic                 clk, rst_n, clk_en, cfg_we;
  logic [2:0]           cfg_ch, cfg_alg;
  logic [1:0]           cfg_rl;
  logic                 adpcma_valid, adpcma_ready;
  logic signed [AW-1:0] adpcma_l_in, adpcma_r_in, adpcma_l, adpcma_r;
  logic                 zero, s1_enters, s2_enters, s3_enters, s4_enters, snd_valid;
  logic [2:0]           cur_ch, alg;
  logic [1:0]           rl;
  logic                 underrun_clr;
  logic [UCW-1:0]       underrun_cnt;

  jt10_acc_seq #(.AW(AW), .UCW(UCW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_alg      (cfg_alg),
    .cfg_rl       (cfg_rl),
    .adpcma_valid (adpcma_valid),
    .adpcma_ready (adpcma_ready),
    .adpcma_l_in  (adpcma_l_in),
    .adpcma_r_in  (adpcma_r_in),
    .adpcma_l     (adpcma_l),
    .adpcma_r     (adpcma_r),
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt),
`endif
    .zero         (zero),
    .cur_ch       (cur_ch),
    .s1_enters    (s1_enters),
    .s2_enters    (s2_enters),
    .s3_enters    (s3_enters),
    .s4_enters    (s4_enters),
    .alg          (alg),
    .rl           (rl),
    .snd_valid    (snd_valid)
  );

`ifndef JT10_ACC_SEQ_UNDERRUN_EN
  assign underrun_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    logic           zero;
    logic [2:0]     cur_ch;
    logic [3:0]     stg;     // {s4, s3, s2, s1}
    logic [2:0]     alg;
    logic [1:0]     rl;
    logic           snd;
    logic [AW-1:0]  l, r;
    logic           ready;
    logic [UCW-1:0] ucnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp, n_bad;

  // Hand-derived slot tables: channel code per slot%6, stage one-hot per slot/6.
  logic [2:0] ch_tab  [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  logic [3:0] stg_tab [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

  int             m_slot;
  logic [2:0]     m_alg_tab [6];
  logic [1:0]     m_rl_tab  [6];
  logic [2:0]     m_alg;
  logic [1:0]     m_rl;
  logic           m_snd, m_pend;
  logic [AW-1:0]  m_l, m_r, m_pl, m_pr;
  logic [UCW-1:0] m_ucnt;

  task automatic m_reset();
    m_slot = 0;
    for (int i = 0; i < 6; i++) begin
      m_alg_tab[i] = 3'd0;
      m_rl_tab[i]  = 2'b11;
    end
    m_alg = 3'd0; m_rl = 2'b11; m_snd = 1'b0; m_pend = 1'b0;
    m_l = '0; m_r = '0; m_pl = '0; m_pr = '0; m_ucnt = '0;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag    = tag;
    e.zero   = (m_slot == 0);
    e.cur_ch = ch_tab[m_slot % 6];
    e.stg    = stg_tab[m_slot / 6];
    e.alg    = m_alg;
    e.rl     = m_rl;
    e.snd    = m_snd;
    e.l      = m_l;
    e.r      = m_r;
    e.ready  = !m_pend;
    e.ucnt   = m_ucnt;
    sb.push_back(e);
  endtask

  // One clk edge with clk_en=en; whatever cfg/handshake inputs are set apply too.
  task automatic step(input bit en, input string tag);
    bit acc, wrap;
    int idx;
    clk_en = en;
    acc    = adpcma_valid && !m_pend;
    wrap   = en && (m_slot == 23);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    if (cfg_we && cfg_ch != 3'd3 && cfg_ch != 3'd7) begin
      idx = (cfg_ch[2] ? 3 : 0) + int'(cfg_ch[1:0]);
      m_alg_tab[idx] = cfg_alg;
      m_rl_tab[idx]  = cfg_rl;
    end
    cfg_we = 1'b0;
    if (wrap) begin
      if (m_pend) begin
        m_l = m_pl; m_r = m_pr; m_pend = 1'b0;
      end else if (m_ucnt != '1) begin
        m_ucnt = m_ucnt + 1'b1;
      end
    end
    if (underrun_clr) m_ucnt = '0;
    underrun_clr = 1'b0;
    if (acc) begin
      m_pend = 1'b1; m_pl = adpcma_l_in; m_pr = adpcma_r_in;
      adpcma_valid = 1'b0;
    end
    if (en) begin
      m_slot = (m_slot == 23) ? 0 : m_slot + 1;
      m_alg  = m_alg_tab[m_slot % 6];
      m_rl   = m_rl_tab[m_slot % 6];
    end
    m_snd = wrap;
    push_exp(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, tag);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [2:0] a,
                           input logic [1:0] r, input bit en, input string tag);
    cfg_we = 1'b1; cfg_ch = ch; cfg_alg = a; cfg_rl = r;
    step(en, tag);
  endtask

  task automatic offer(input logic [AW-1:0] l, input logic [AW-1:0] r);
    adpcma_valid = 1'b1; adpcma_l_in = l; adpcma_r_in = r;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if ({zero, cur_ch, s4_enters, s3_enters, s2_enters, s1_enters, alg, rl, snd_valid, adpcma_ready}
          !== {mon_e.zero, mon_e.cur_ch, mon_e.stg, mon_e.alg, mon_e.rl, mon_e.snd, mon_e.ready}
          || adpcma_l !== mon_e.l || adpcma_r !== mon_e.r
`ifdef JT10_ACC_SEQ_UNDERRUN_EN
          || underrun_cnt !== mon_e.ucnt
`endif
          ) begin
        n_bad++;
        $display("FAIL %s: got zero=%b ch=%0d stg=%b alg=%0d rl=%b snd=%b rdy=%b l=%h r=%h ucnt=%0d ; expected zero=%b ch=%0d stg=%b alg=%0d rl=%b snd=%b rdy=%b l=%h r=%h ucnt=%0d",
                 mon_e.tag, zero, cur_ch, {s4_enters, s3_enters, s2_enters, s1_enters}, alg, rl,
                 snd_valid, adpcma_ready, adpcma_l, adpcma_r, underrun_cnt,
                 mon_e.zero, mon_e.cur_ch, mon_e.stg, mon_e.alg, mon_e.rl, mon_e.snd,
                 mon_e.ready, mon_e.l, mon_e.r, mon_e.ucnt);
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; clk_en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_alg = '0; cfg_rl = '0;
    adpcma_valid = 1'b0; adpcma_l_in = '0; adpcma_r_in = '0; underrun_clr = 1'b0;
    #1;
    m_reset();
    push_exp("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Full round: zero, channel order, stage order, snd_valid on wrap.
    ticks(24, "round0");

    // Config writes: ch5 applied off clk_en, ch3 ignored, ch2 bypassed on entry.
    cfg_write(3'd5, 3'd4, 2'b10, 1'b0, "cfg5_write");
    cfg_write(3'd3, 3'd7, 2'b00, 1'b0, "cfg3_ignored");
    ticks(1, "cfg_round");
    cfg_write(3'd2, 3'd3, 2'b01, 1'b1, "cfg2_bypass");
    ticks(22, "cfg_round");

    // First sample mid-round, second held valid while pending.
    ticks(5, "pre_accept");
    offer(16'h1234, 16'h8001);
    step(1'b1, "accept1");
    offer(16'h7fff, 16'h8000);
    for (int i = 0; i < 40 && adpcma_valid; i++) step(1'b1, "hold2");
    if (adpcma_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL hold2_accept: got no accept within 40 slots, required accept after round transfer");
      adpcma_valid = 1'b0;
    end
    ticks(23, "second_round");

    // Three rounds with no sample after a counter clear.
    underrun_clr = 1'b1;
    step(1'b0, "ucnt_clr0");
    ticks(72, "underrun");
    underrun_clr = 1'b1;
    step(1'b0, "ucnt_clr1");

    // Asynchronous reset at slot 13 with a sample pending.
    ticks(2, "pre_rst");
    offer(16'h0abc, 16'hf00d);
    ticks(11, "pre_rst");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    push_exp("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // clk_en low for 10 clocks with an accept in the middle.
    ticks(3, "pre_freeze");
    for (int i = 0; i < 4; i++) step(1'b0, "freeze");
    offer(16'h4321, 16'hc0de);
    step(1'b0, "freeze_accept");
    for (int i = 0; i < 5; i++) step(1'b0, "freeze");
    ticks(21, "post_freeze");
    ticks(2, "post_wrap");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt10_acc_seq.md
Name: jt10_acc_seq

Overview:
- Slot sequencer and configuration holder for the YM2610 accumulator datapath.
- Walks the 24-slot round (4 operator stages x 6 FM channels) and generates the per-slot controls: zero, cur_ch, s1..s4_enters, alg and rl.
- Double-buffers ADPCM-A L/R samples, which arrive through a valid/ready handshake, so the value presented to the accumulator is stable for a whole round.
- Sits between the register interface / ADPCM-A engine and the stereo accumulator.

Parameters:
- AW, 16, ADPCM-A sample width (signed).
- UCW, 8, underrun counter width (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  slot advance enable; all state except handshake/config updates on clk_en only.
- cfg_we  in  1  per-channel config write strobe.
- cfg_ch  in  3  channel code {group, idx}; valid 0,1,2,4,5,6.
- cfg_alg  in  3  algorithm for cfg_ch.
- cfg_rl  in  2  output enables {L,R} for cfg_ch.
- adpcma_valid  in  1  sample offered.
- adpcma_ready  out  1  pending buffer empty.
- adpcma_l_in, adpcma_r_in  in  AW  offered sample.
- adpcma_l, adpcma_r  out  AW  round-stable sample to accumulator.
- zero  out  1  first slot of round.
- cur_ch  out  3  current channel code.
- s1_enters, s2_enters, s3_enters, s4_enters  out  1  one-hot operator stage.
- alg  out  3  alg of cur_ch.
- rl  out  2  rl of cur_ch.
- snd_valid  out  1  one-clk pulse: accumulator output final.

Behaviour:
- State:
  - slot counter 0..23.
  - 6-entry config RAM of 5 bits {alg, rl}.
  - pending buffer {pl, pr, pend_full}.
  - output buffer {adpcma_l, adpcma_r}.
- Reset values: slot=0, zero=1, cur_ch=0, s1_enters=1 and others 0; config RAM all alg=0, rl=2'b11; buffers 0; pend_full=0; snd_valid=0.
- Slot decode, all outputs registered and updated on the clk_en edge that enters the new slot:
  - stage = slot/6, mapped 0->S1, 1->S3, 2->S2, 3->S4.
  - chidx = slot%6; cur_ch = {chidx>=3, chidx%3}.
  - zero = (slot==0).
  - Slot wraps 23->0.
- alg/rl: taken from config RAM at the next slot's channel.
  - A cfg_we on the same edge targeting that channel is bypassed, so the new value is visible immediately.
- Config writes apply on any clk edge, independent of clk_en. cfg_ch 3 or 7 is ignored (no RAM change).
- Handshake: adpcma_ready = ~pend_full, combinational from the register.
  - Transfer occurs when valid & ready at an edge; it sets pend_full=1 and latches the inputs.
  - Valid without ready: no effect; the producer must hold.
- Round transfer: on the clk_en edge slot 23->0 with pend_full=1: outputs <= pending, pend_full <= 0.
  - With pend_full=0: outputs hold the previous sample (underrun).
  - Same edge with a handshake accept and a round transfer cannot occur, because ready=0 whenever the pending buffer is moved.
- snd_valid = 1 for exactly one clk on the slot 23->0 edge; otherwise 0.
- clk_en=0: slot, outputs and snd_valid are frozen/0; the handshake and config writes still operate.
- Reset mid-round: asynchronous return to the reset state; any pending sample is discarded.

Optional Feature:
- Macro: JT10_ACC_SEQ_UNDERRUN_EN.
- Defined:
  - Adds output port underrun_cnt [UCW-1:0], reset 0.
  - Increments on each 23->0 edge with pend_full=0, saturating at all-ones.
  - Adds input underrun_clr, which zeroes the counter synchronously; clr wins over a simultaneous increment.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package jt10_seq_pkg:
  - SLOTS=24, CHANNELS=6.
  - Stage enum {ST_S1, ST_S3, ST_S2, ST_S4}.
  - Function ch_code(chidx)->3-bit code.
  - Function ch_valid(code).
- Sub-module jt10_adpcma_buf: pending plus output double buffer with handshake and the underrun logic.
- The slot counter and config RAM stay in the top module.

Test Plan:
- Reset then 24 clk_en ticks:
  - zero=1 only at slot 0.
  - cur_ch sequence 0,1,2,4,5,6 repeated; stage order S1,S3,S2,S4 every 6 slots.
  - snd_valid pulses once, at the 23->0 edge.
- cfg_we ch=5, alg=4, rl=2'b10:
  - alg=4, rl=2'b10 at every slot with cur_ch=5; other channels keep alg=0, rl=2'b11.
  - Write with cfg_ch=3: no RAM change.
- Offer sample L=16'h1234, R=16'h8001 mid-round:
  - ready drops after the accept.
  - adpcma_l/r change only at the next 23->0 edge; ready returns to 1 on that edge.
- Hold valid high with a new sample while pend_full:
  - No acceptance until the round transfer; the second sample appears exactly one round after the first.
- No sample offered for 3 rounds:
  - Outputs hold the last value.
  - With JT10_ACC_SEQ_UNDERRUN_EN: underrun_cnt=3; asserting underrun_clr -> 0.
- Assert rst_n=0 at slot 13 with a sample pending:
  - Immediate reset values: slot 0, pend_full=0, outputs 0.
- clk_en held low for 10 clks:
  - Slot and all slot outputs frozen.
  - A handshake accept still occurs.
